i2f_seq: RTL and testbench

- Sequential integer-to-float converter; the reverse direction of the ALU's float-to-integer path.
- Takes a signed two's-complement integer of NUBITS and returns a float word {sign, biased exponent, mantissa}, with the hidden bit dropped.
- Normalises iteratively, one left shift per cycle.
- Sits beside ula_fx as a multi-cycle co-unit under start/busy/done control from the processor's control unit.

---
 rtl/i2f_seq_pkg.sv | 22 ++
 rtl/i2f_seq_if.sv | 13 +
 rtl/i2f_pack.sv | 24 ++
 rtl/i2f_seq.sv | 109 ++++++++++
 tb/tb_i2f_seq.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/i2f_seq_pkg.sv
// Shared constants and state encoding for the sequential integer-to-float
// converter.
package i2f_seq_pkg;

  localparam int NUBITS_DEF = 32;
  localparam int NBMANT_DEF = 23;
  localparam int NBEXPO_DEF = 8;

  localparam int F_BIAS   = 2 ** (NBEXPO_DEF - 1) - 1;
  localparam int MANT_MSB = NUBITS_DEF - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    PACK = 2'd2
  } state_t;

  function automatic int bias_of(input int nbexpo);
    return (1 << (nbexpo - 1)) - 1;
  endfunction

endpackage

// File: rtl/i2f_seq_if.sv
// Start/busy/done handshake and operand/result bus of the converter.
interface i2f_seq_if #(
  parameter int NUBITS = 32
);
  logic              start;
  logic [NUBITS-1:0] in;
  logic [NUBITS-1:0] out;
  logic              busy;
  logic              done;

  modport master (output start, in, input out, busy, done);
  modport slave  (input start, in, output out, busy, done);
endinterface

// File: rtl/i2f_pack.sv
// Combinational packer: assembles {sign, exponent, mantissa} or forces zero.
module i2f_pack
  import i2f_seq_pkg::*;
#(
  parameter int NUBITS = NUBITS_DEF,
  parameter int NBEXPO = NBEXPO_DEF,
  parameter int NBMANT = NBMANT_DEF
) (
  input  logic              sign,
  input  logic [NBEXPO-1:0] exp,
  input  logic [NBMANT-1:0] mant,
  input  logic              zflag,
  output logic [NUBITS-1:0] word
);

  // Zero input bypasses the fields entirely, so negative zero cannot occur.
  always_comb begin
    word = '0;
    if (!zflag) begin
      word = {sign, exp, mant};
    end
  end

endmodule

// File: rtl/i2f_seq.sv
// Sequential signed-integer to float converter; normalises with one left
// shift per cycle and truncates the magnitude into the mantissa.
module i2f_seq
  import i2f_seq_pkg::*;
#(
  parameter int NUBITS = NUBITS_DEF,
  parameter int NBMANT = NBMANT_DEF,
  parameter int NBEXPO = NBEXPO_DEF
) (
  input  logic      clk,
  input  logic      rst,
  i2f_seq_if.slave  bus
);

  localparam logic [NBEXPO-1:0] EXP_INIT = NBEXPO'(bias_of(NBEXPO) + NUBITS - 1);

  state_t              state;
  state_t              state_nxt;
  logic [NUBITS-1:0]   mag;
  logic [NUBITS-1:0]   in_abs;
  logic [NBEXPO-1:0]   exp;
  logic                sign;
  logic                zflag;
  logic [NUBITS-1:0]   out_q;
  logic                done_q;
  logic [NBMANT-1:0]   mant;
  logic [NUBITS-1:0]   packed_word;

  // Unsigned magnitude; the most negative value maps onto itself without overflow.
  assign in_abs = bus.in[NUBITS-1] ? (~bus.in + 1'b1) : bus.in;
  assign mant   = mag[NUBITS-2 -: NBMANT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = (bus.in == '0) ? PACK : NORM;
        end
      end
      NORM: begin
        if (mag[NUBITS-1]) begin
          state_nxt = PACK;
        end
      end
      PACK:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mag    <= '0;
      exp    <= '0;
      sign   <= 1'b0;
      zflag  <= 1'b0;
      out_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == PACK);
      case (state)
        IDLE: begin
          if (bus.start) begin
            sign  <= bus.in[NUBITS-1];
            mag   <= in_abs;
            exp   <= EXP_INIT;
            zflag <= (bus.in == '0);
          end
        end
        NORM: begin
          if (!mag[NUBITS-1]) begin
            mag <= mag << 1;
            exp <= exp - 1'b1;
          end
        end
        PACK: begin
          out_q <= packed_word;
        end
        default: begin
        end
      endcase
    end
  end

  i2f_pack #(
    .NUBITS (NUBITS),
    .NBEXPO (NBEXPO),
    .NBMANT (NBMANT)
  ) u_pack (
    .sign  (sign),
    .exp   (exp),
    .mant  (mant),
    .zflag (zflag),
    .word  (packed_word)
  );

  assign bus.out  = out_q;
  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;

endmodule

// File: tb/tb_i2f_seq.sv
// Directed self-checking bench for i2f_seq with hand-computed float words.
module tb_i2f_seq;
  import i2f_seq_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   passed;
  int   done_cnt;
  bit   cnt_en;

  i2f_seq_if #(.NUBITS(32)) bus ();

  i2f_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cnt_en && bus.done === 1'b1) done_cnt++;
  end

  // Accepts one operand and waits for done; edges counts from the accepting edge.
  task automatic convert(input logic [31:0] val, output int edges,
                         output logic [31:0] res, output bit busy_ok,
                         output bit timed_out);
    @(negedge clk);
    bus.in    = val;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.in    = 32'hDEAD_BEEF;
    busy_ok   = (bus.busy === 1'b1);
    edges     = 0;
    timed_out = 1'b1;
    res       = 'x;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.done === 1'b1) begin
        timed_out = 1'b0;
        res       = bus.out;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic run_case(input string name, input logic [31:0] val,
                          input logic [31:0] exp_out, input int exp_edges);
    int          edges;
    logic [31:0] res;
    bit          busy_ok;
    bit          timed_out;
    convert(val, edges, res, busy_ok, timed_out);
    total++;
    if (timed_out !== 1'b0) $display("[TB] FAIL %s timeout: no done within 100 edges", name);
    else passed++;
    total++;
    if (res !== exp_out) $display("[TB] FAIL %s out: got %h want %h", name, res, exp_out);
    else passed++;
    total++;
    if (edges !== exp_edges) $display("[TB] FAIL %s latency: got %0d want %0d", name, edges, exp_edges);
    else passed++;
    total++;
    if (busy_ok !== 1'b1) $display("[TB] FAIL %s busy: got dropped want held", name);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (bus.done !== 1'b0) $display("[TB] FAIL %s done_width: got %b want 0", name, bus.done);
    else passed++;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.in    = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.out !== 32'h0) $display("[TB] FAIL reset_out: got %h want 0", bus.out);
    else passed++;
    total++;
    if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", bus.busy);
    else passed++;
    total++;
    if (bus.done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", bus.done);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_one();
    run_case("one", 32'h0000_0001, 32'h3F80_0000, 33);
  endtask

  task automatic test_neg_two();
    run_case("neg_two", 32'hFFFF_FFFE, 32'hC000_0000, 32);
  endtask

  task automatic test_zero();
    run_case("zero", 32'h0000_0000, 32'h0000_0000, 1);
    total++;
    if (bus.out[31] !== 1'b0) $display("[TB] FAIL zero_sign: got %b want 0", bus.out[31]);
    else passed++;
  endtask

  task automatic test_min();
    run_case("min_int", 32'h8000_0000, 32'hCF00_0000, 2);
  endtask

  task automatic test_trunc();
    run_case("trunc", 32'h0100_0001, 32'h4B80_0000, 9);
  endtask

  task automatic test_back_to_back();
    bit got;
    done_cnt = 0;
    cnt_en   = 1'b1;
    @(negedge clk);
    bus.in    = 32'd5;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.in    = 32'd7;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    total++;
    if (got !== 1'b1) $display("[TB] FAIL b2b_first_timeout: no done within 100 edges");
    else passed++;
    total++;
    if (bus.out !== 32'h40A0_0000) $display("[TB] FAIL ignore_start_out: got %h want 40a00000", bus.out);
    else passed++;
    bus.in    = 32'd3;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b1) $display("[TB] FAIL b2b_accept: busy got %b want 1", bus.busy);
    else passed++;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    total++;
    if (got !== 1'b1) $display("[TB] FAIL b2b_second_timeout: no done within 100 edges");
    else passed++;
    total++;
    if (bus.out !== 32'h4040_0000) $display("[TB] FAIL b2b_out: got %h want 40400000", bus.out);
    else passed++;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (done_cnt !== 2) $display("[TB] FAIL b2b_done_count: got %0d want 2", done_cnt);
    else passed++;
    cnt_en = 1'b0;
  endtask

  task automatic test_abort();
    @(negedge clk);
    bus.in    = 32'h0000_1000;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (bus.busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b want 0", bus.busy);
    else passed++;
    total++;
    if (bus.done !== 1'b0) $display("[TB] FAIL abort_done: got %b want 0", bus.done);
    else passed++;
    total++;
    if (bus.out !== 32'h0) $display("[TB] FAIL abort_out: got %h want 0", bus.out);
    else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst      = 1'b1;
    done_cnt = 0;
    cnt_en   = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    cnt_en = 1'b0;
    total++;
    if (done_cnt !== 0) $display("[TB] FAIL abort_no_done: got %0d pulses want 0", done_cnt);
    else passed++;
    run_case("after_abort", 32'd100, 32'h42C8_0000, 27);
  endtask

  initial begin
    total    = 0;
    passed   = 0;
    done_cnt = 0;
    cnt_en   = 1'b0;
    $display("[TB] i2f_seq bench start, bias %0d", F_BIAS);
    test_reset();
    test_one();
    test_neg_two();
    test_zero();
    test_min();
    test_trunc();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
